// File: rtl/csel_adder_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : csel_adder_pipe_if
// Brief    : Stream bundle for the pipelined carry-select adder.
// Revision : 1.0
// ============================================================================
interface csel_adder_pipe_if #(
    parameter int WIDTH = 16,
    parameter int FIW   = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             fi_en;
    logic [FIW-1:0]   fi_blk;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             err;
    logic [15:0]      err_cnt;

    modport master (
        output in_valid, a, b, cin, fi_en, fi_blk, out_ready,
        input  in_ready, out_valid, sum, cout, err, err_cnt
    );

    modport slave (
        input  in_valid, a, b, cin, fi_en, fi_blk, out_ready,
        output in_ready, out_valid, sum, cout, err, err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/csel_adder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : csel_adder_pipe
// Brief    : Pipelined carry-select adder, valid/ready stream, with reference
//            checker and per-block select fault injection.
// Revision : 1.0
// ============================================================================
module csel_adder_pipe #(
    parameter int WIDTH          = 16,
    parameter int BLK            = 4,
    parameter int BLKS_PER_STAGE = 2,
    parameter int CHECK_EN       = 1
) (
    input  wire logic           clk,
    input  wire logic           rst,
    csel_adder_pipe_if.slave    bus
);
    localparam int NB  = WIDTH / BLK;
    localparam int NS  = (NB + BLKS_PER_STAGE - 1) / BLKS_PER_STAGE;
    localparam int FIW = (NB > 1) ? $clog2(NB) : 1;

    // Resolves the blocks owned by stage s; returns {carry_out, sum}.
    function automatic logic [WIDTH:0] f_resolve(
        input int               s,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [WIDTH-1:0] sum_in,
        input logic             c_in,
        input logic             fe,
        input logic [FIW-1:0]   fb
    );
        logic [WIDTH-1:0] sm;
        logic             c;
        logic [BLK:0]     s0;
        logic [BLK:0]     s1;
        logic [BLK:0]     sel;
        logic             inv;
        sm = sum_in;
        c  = c_in;
        for (int j = 0; j < NB; j++) begin
            if (j / BLKS_PER_STAGE == s) begin
                s0  = {1'b0, a[j*BLK +: BLK]} + {1'b0, b[j*BLK +: BLK]};
                s1  = s0 + {{BLK{1'b0}}, 1'b1};
                inv = fe && (int'(fb) == j);
                sel = (c ^ inv) ? s1 : s0;
                sm[j*BLK +: BLK] = sel[BLK-1:0];
                c   = sel[BLK];
            end
        end
        return {c, sm};
    endfunction

    logic             r_vld [NS];
    logic [WIDTH-1:0] r_a   [NS];
    logic [WIDTH-1:0] r_b   [NS];
    logic [WIDTH-1:0] r_sum [NS];
    logic             r_c   [NS];
    logic             r_fe  [NS];
    logic [FIW-1:0]   r_fb  [NS];
    logic [WIDTH:0]   w_res [NS];
    logic             w_adv;

    assign w_adv         = bus.out_ready | ~r_vld[NS-1];
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = r_vld[NS-1];
    assign bus.sum       = r_sum[NS-1];
    assign bus.cout      = r_c[NS-1];

    for (genvar s = 0; s < NS; s++) begin : g_stage
        if (s == 0) begin : g_first
            assign w_res[s] = f_resolve(0, bus.a, bus.b, '0, bus.cin,
                                        bus.fi_en, bus.fi_blk);
        end else begin : g_next
            assign w_res[s] = f_resolve(s, r_a[s-1], r_b[s-1], r_sum[s-1],
                                        r_c[s-1], r_fe[s-1], r_fb[s-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NS; s++) begin
                r_vld[s] <= 1'b0;
                r_a[s]   <= '0;
                r_b[s]   <= '0;
                r_sum[s] <= '0;
                r_c[s]   <= 1'b0;
                r_fe[s]  <= 1'b0;
                r_fb[s]  <= '0;
            end
        end else if (w_adv) begin
            r_vld[0] <= bus.in_valid;
            r_a[0]   <= bus.a;
            r_b[0]   <= bus.b;
            r_sum[0] <= w_res[0][WIDTH-1:0];
            r_c[0]   <= w_res[0][WIDTH];
            r_fe[0]  <= bus.fi_en;
            r_fb[0]  <= bus.fi_blk;
            for (int s = 1; s < NS; s++) begin
                r_vld[s] <= r_vld[s-1];
                r_a[s]   <= r_a[s-1];
                r_b[s]   <= r_b[s-1];
                r_sum[s] <= w_res[s][WIDTH-1:0];
                r_c[s]   <= w_res[s][WIDTH];
                r_fe[s]  <= r_fe[s-1];
                r_fb[s]  <= r_fb[s-1];
            end
        end
    end

    if (CHECK_EN != 0) begin : g_chk
        logic [WIDTH:0] r_ref [NS];
        logic [15:0]    r_err_cnt;
        logic           w_err;

        assign w_err       = r_vld[NS-1] && ({r_c[NS-1], r_sum[NS-1]} != r_ref[NS-1]);
        assign bus.err     = w_err;
        assign bus.err_cnt = r_err_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int s = 0; s < NS; s++) begin
                    r_ref[s] <= '0;
                end
                r_err_cnt <= 16'd0;
            end else begin
                if (w_adv) begin
                    r_ref[0] <= {1'b0, bus.a} + {1'b0, bus.b} + {{WIDTH{1'b0}}, bus.cin};
                    for (int s = 1; s < NS; s++) begin
                        r_ref[s] <= r_ref[s-1];
                    end
                end
                // Counts delivered transactions only, so a held output is counted once.
                if (w_err && bus.out_ready && r_err_cnt != 16'hFFFF) begin
                    r_err_cnt <= r_err_cnt + 16'd1;
                end
            end
        end
    end else begin : g_nochk
        assign bus.err     = 1'b0;
        assign bus.err_cnt = 16'd0;
    end
endmodule
`default_nettype wire
